rfphoenix_store_fwd_queue: RTL and testbench

- Parametrised circular store queue between the Phoenix AGEN/memory stage and the data-cache write port.
- Holds committed-pending stores at line granularity and coalesces back-to-back same-line stores from one thread.
- Forwards byte-merged store data to NLDP concurrent load lookups.
- Kills per-thread entries on rollback.

---
 rtl/rfphoenix_store_fwd_queue.sv | 189 ++++++++++++++++++
 tb/tb_rfphoenix_store_fwd_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_store_fwd_queue.sv
// Circular store queue between AGEN/memory and the data-cache write port.
// Coalesces back-to-back same-line stores from one thread, forwards
// byte-merged data to load lookups and kills per-thread entries on rollback.
module rfphoenix_store_fwd_queue #(
  parameter int AWID     = 32,
  parameter int QDEP     = 8,
  parameter int LANEB    = 16,
  parameter int NTHREADS = 4,
  parameter int NLDP     = 2,
  parameter int MERGE_EN = 1,
  localparam int TIDW    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
  localparam int PTRW    = $clog2(QDEP),
  localparam int CNTW    = PTRW + 1,
  localparam int OFFW    = $clog2(LANEB),
  localparam int LINEW   = AWID - OFFW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_v_i,
  output logic                     enq_rdy_o,
  input  logic [AWID-1:0]          enq_adr_i,
  input  logic [LANEB-1:0]         enq_sel_i,
  input  logic [8*LANEB-1:0]       enq_dat_i,
  input  logic [TIDW-1:0]          enq_thread_i,
  output logic                     deq_v_o,
  input  logic                     deq_rdy_i,
  output logic [AWID-1:0]          deq_adr_o,
  output logic [LANEB-1:0]         deq_sel_o,
  output logic [8*LANEB-1:0]       deq_dat_o,
  output logic [TIDW-1:0]          deq_thread_o,
  input  logic [NLDP*AWID-1:0]     ld_adr_i,
  input  logic [NLDP*LANEB-1:0]    ld_sel_i,
  output logic [NLDP-1:0]          ld_hit_o,
  output logic [NLDP-1:0]          ld_conflict_o,
  output logic [NLDP*8*LANEB-1:0]  ld_dat_o,
  input  logic [NTHREADS-1:0]      rollback_i,
  output logic [NTHREADS-1:0]      thread_busy_o,
  output logic [CNTW-1:0]          count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  logic [LINEW-1:0]   line_q [QDEP];
  logic [LANEB-1:0]   sel_q  [QDEP];
  logic [8*LANEB-1:0] dat_q  [QDEP];
  logic [TIDW-1:0]    thr_q  [QDEP];
  logic [QDEP-1:0]    live_q, live_d;
  logic [PTRW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]    count_q, count_d;

  logic [PTRW-1:0]    youngIdx;
  logic [LINEW-1:0]   enqLine;
  logic               mergeHit, alloc, retire;
  logic [8*LANEB-1:0] mergedDat;
  logic               fwdCov, fwdAny, fwdFound;
  logic [7:0]         fwdByte;
  logic [PTRW-1:0]    fwdIdx;
  logic               unused_ok;

  assign unused_ok = ^{enq_adr_i[OFFW-1:0], ld_adr_i};

  assign full_o    = (count_q == CNTW'(QDEP));
  assign empty_o   = (count_q == '0);
  assign enq_rdy_o = !full_o;
  assign count_o   = count_q;

  assign youngIdx  = tail_q - PTRW'(1);
  assign enqLine   = enq_adr_i[AWID-1:OFFW];

  assign deq_v_o      = !empty_o && live_q[head_q];
  assign deq_adr_o    = {line_q[head_q], {OFFW{1'b0}}};
  assign deq_sel_o    = sel_q[head_q];
  assign deq_dat_o    = dat_q[head_q];
  assign deq_thread_o = thr_q[head_q];

  // Handshake decode: retire (live handshake or dead head), coalesce, allocate.
  always_comb begin
    retire   = !empty_o && (!live_q[head_q] || deq_rdy_i);
    mergeHit = (MERGE_EN != 0) && enq_v_i && !empty_o && live_q[youngIdx]
               && (line_q[youngIdx] == enqLine) && (thr_q[youngIdx] == enq_thread_i)
               && !(retire && (youngIdx == head_q));
    alloc    = enq_v_i && !full_o && !mergeHit;
    for (int b = 0; b < LANEB; b++) begin
      mergedDat[8*b +: 8] = enq_sel_i[b] ? enq_dat_i[8*b +: 8] : dat_q[youngIdx][8*b +: 8];
    end
  end

  // Next pointers, occupancy and live bits (rollback kills, retire clears, alloc sets).
  always_comb begin
    head_d  = retire ? head_q + PTRW'(1) : head_q;
    tail_d  = alloc  ? tail_q + PTRW'(1) : tail_q;
    count_d = count_q;
    case ({alloc, retire})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    live_d = live_q;
    for (int i = 0; i < QDEP; i++) begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (rollback_i[t] && (thr_q[i] == TIDW'(t))) live_d[i] = 1'b0;
      end
    end
    if (retire) live_d[head_q] = 1'b0;
    if (alloc) begin
      live_d[tail_q] = 1'b1;
      for (int t = 0; t < NTHREADS; t++) begin
        if (rollback_i[t] && (enq_thread_i == TIDW'(t))) live_d[tail_q] = 1'b0;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // Entry payload; only meaningful while the matching live bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      line_q[tail_q] <= enqLine;
      sel_q[tail_q]  <= enq_sel_i;
      dat_q[tail_q]  <= enq_dat_i;
      thr_q[tail_q]  <= enq_thread_i;
    end else if (mergeHit) begin
      sel_q[youngIdx] <= sel_q[youngIdx] | enq_sel_i;
      dat_q[youngIdx] <= mergedDat;
    end
  end

  // Thread occupancy from live entries.
  always_comb begin
    thread_busy_o = '0;
    for (int i = 0; i < QDEP; i++) begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (live_q[i] && (thr_q[i] == TIDW'(t))) thread_busy_o[t] = 1'b1;
      end
    end
  end

  // Load forwarding: walk oldest to youngest so the youngest matching byte wins.
  always_comb begin
    ld_hit_o      = '0;
    ld_conflict_o = '0;
    ld_dat_o      = '0;
    fwdCov        = 1'b1;
    fwdAny        = 1'b0;
    fwdFound      = 1'b0;
    fwdByte       = '0;
    fwdIdx        = '0;
    for (int p = 0; p < NLDP; p++) begin
      fwdCov = 1'b1;
      fwdAny = 1'b0;
      for (int b = 0; b < LANEB; b++) begin
        fwdFound = 1'b0;
        fwdByte  = '0;
        for (int k = 0; k < QDEP; k++) begin
          fwdIdx = head_q + PTRW'(k);
          if (live_q[fwdIdx] && sel_q[fwdIdx][b]
              && (line_q[fwdIdx] == ld_adr_i[p*AWID+OFFW +: LINEW])) begin
            fwdFound = 1'b1;
            fwdByte  = dat_q[fwdIdx][8*b +: 8];
          end
        end
        if (ld_sel_i[p*LANEB+b]) begin
          if (fwdFound) begin
            fwdAny = 1'b1;
            ld_dat_o[(p*LANEB+b)*8 +: 8] = fwdByte;
          end else begin
            fwdCov = 1'b0;
          end
        end
      end
      ld_hit_o[p]      = fwdCov && (|ld_sel_i[p*LANEB +: LANEB]);
      ld_conflict_o[p] = (|ld_sel_i[p*LANEB +: LANEB]) && !fwdCov && fwdAny;
    end
  end

endmodule

// File: tb/tb_rfphoenix_store_fwd_queue.sv
// Directed bench for rfphoenix_store_fwd_queue; a second instance with
// coalescing disabled shares the same stimulus.
module tb_rfphoenix_store_fwd_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         enqV;
  logic [31:0]  enqAdr;
  logic [15:0]  enqSel;
  logic [127:0] enqDat;
  logic [1:0]   enqThread;
  logic         deqRdy;
  logic [63:0]  ldAdr;
  logic [31:0]  ldSel;
  logic [3:0]   rollback;

  logic         enqRdy, deqV, full, empty;
  logic [31:0]  deqAdr;
  logic [15:0]  deqSel;
  logic [127:0] deqDat;
  logic [1:0]   deqThread, ldHit, ldConflict;
  logic [255:0] ldDat;
  logic [3:0]   threadBusy, count;

  logic         nmEnqRdy, nmDeqV, nmFull, nmEmpty;
  logic [31:0]  nmDeqAdr;
  logic [15:0]  nmDeqSel;
  logic [127:0] nmDeqDat;
  logic [1:0]   nmDeqThread, nmLdHit, nmLdConflict;
  logic [255:0] nmLdDat;
  logic [3:0]   nmThreadBusy, nmCount;

  int checks = 0;
  int errors = 0;

  rfphoenix_store_fwd_queue dut (
    .clk(clk), .rst(rst),
    .enq_v_i(enqV), .enq_rdy_o(enqRdy), .enq_adr_i(enqAdr), .enq_sel_i(enqSel),
    .enq_dat_i(enqDat), .enq_thread_i(enqThread),
    .deq_v_o(deqV), .deq_rdy_i(deqRdy), .deq_adr_o(deqAdr), .deq_sel_o(deqSel),
    .deq_dat_o(deqDat), .deq_thread_o(deqThread),
    .ld_adr_i(ldAdr), .ld_sel_i(ldSel), .ld_hit_o(ldHit), .ld_conflict_o(ldConflict),
    .ld_dat_o(ldDat), .rollback_i(rollback), .thread_busy_o(threadBusy),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  rfphoenix_store_fwd_queue #(.MERGE_EN(0)) dutNoMerge (
    .clk(clk), .rst(rst),
    .enq_v_i(enqV), .enq_rdy_o(nmEnqRdy), .enq_adr_i(enqAdr), .enq_sel_i(enqSel),
    .enq_dat_i(enqDat), .enq_thread_i(enqThread),
    .deq_v_o(nmDeqV), .deq_rdy_i(deqRdy), .deq_adr_o(nmDeqAdr), .deq_sel_o(nmDeqSel),
    .deq_dat_o(nmDeqDat), .deq_thread_o(nmDeqThread),
    .ld_adr_i(ldAdr), .ld_sel_i(ldSel), .ld_hit_o(nmLdHit), .ld_conflict_o(nmLdConflict),
    .ld_dat_o(nmLdDat), .rollback_i(rollback), .thread_busy_o(nmThreadBusy),
    .count_o(nmCount), .full_o(nmFull), .empty_o(nmEmpty)
  );

  // Free-running clock, posedge every 10 time units.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] adr, input logic [15:0] sel,
                               input logic [7:0] b, input logic [1:0] thr,
                               input logic rdy, input logic [3:0] rb);
    enqV      = v;
    enqAdr    = adr;
    enqSel    = sel;
    enqDat    = {16{b}};
    enqThread = thr;
    deqRdy    = rdy;
    rollback  = rb;
    @(posedge clk);
    #1;
    enqV     = 1'b0;
    deqRdy   = 1'b0;
    rollback = 4'b0;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; enqV = 1'b0; enqAdr = '0; enqSel = '0; enqDat = '0; enqThread = '0;
    deqRdy = 1'b0; ldAdr = '0; ldSel = '0; rollback = '0;
    #3;
    checkOutput("rst_enq_rdy", enqRdy, 1);
    checkOutput("rst_deq_v", deqV, 0);
    checkOutput("rst_ld_hit", ldHit, 0);
    checkOutput("rst_ld_conflict", ldConflict, 0);
    checkOutput("rst_ld_dat", ldDat, 0);
    checkOutput("rst_busy", threadBusy, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_count", count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    $display("[TB] fill");
    for (int i = 0; i < 8; i++) applyStimulus(1, 32'h100 + i*16, 16'hFFFF, 8'(i), 0, 0, 0);
    checkOutput("fill_count", count, 8);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_enq_rdy", enqRdy, 0);
    checkOutput("fill_busy", threadBusy, 4'b0001);
    checkOutput("fill_deq_v", deqV, 1);
    checkOutput("fill_deq_adr", deqAdr, 32'h100);
    applyStimulus(1, 32'h180, 16'hFFFF, 8'h99, 0, 0, 0);
    checkOutput("fill_9th_count", count, 8);
    applyStimulus(1, 32'h170, 16'h0001, 8'hEE, 0, 0, 0);
    checkOutput("full_merge_count", count, 8);
    checkOutput("full_nomerge_count", nmCount, 8);
    ldAdr[31:0] = 32'h170; ldSel[15:0] = 16'h0003;
    #1;
    checkOutput("full_merge_hit", ldHit, 2'b01);
    checkOutput("full_merge_dat", ldDat[15:0], 16'h07EE);
    ldSel = '0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_adr", deqAdr, 32'h100 + i*16);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
    end
    checkOutput("drain_empty", empty, 1);
    checkOutput("drain_count", count, 0);

    $display("[TB] coalesce");
    doReset();
    applyStimulus(1, 32'h200, 16'h000F, 8'h11, 1, 0, 0);
    applyStimulus(1, 32'h204, 16'h00F0, 8'h22, 1, 0, 0);
    checkOutput("merge_count", count, 1);
    checkOutput("merge_sel", deqSel, 16'h00FF);
    checkOutput("merge_dat", deqDat[63:0], 64'h2222222211111111);
    checkOutput("merge_thread", deqThread, 1);
    checkOutput("nomerge_count", nmCount, 2);
    applyStimulus(1, 32'h200, 16'h0F00, 8'h33, 2, 0, 0);
    checkOutput("xthread_count", count, 2);
    checkOutput("xthread_busy", threadBusy, 4'b0110);

    $display("[TB] forwarding");
    doReset();
    applyStimulus(1, 32'h300, 16'h000F, 8'hAA, 0, 0, 0);
    applyStimulus(1, 32'h300, 16'h0003, 8'hBB, 1, 0, 0);
    checkOutput("fwd_count", count, 2);
    ldAdr = {32'h300, 32'h300}; ldSel = {16'h001F, 16'h000F};
    #1;
    checkOutput("fwd_hit", ldHit, 2'b01);
    checkOutput("fwd_conflict", ldConflict, 2'b10);
    checkOutput("fwd_dat0", ldDat[127:0], 128'hAAAABBBB);
    checkOutput("fwd_dat1", ldDat[255:128], 128'hAAAABBBB);
    ldAdr = {32'h400, 32'h300}; ldSel = {16'hFFFF, 16'h0000};
    #1;
    checkOutput("fwd_miss_hit", ldHit, 0);
    checkOutput("fwd_miss_conflict", ldConflict, 0);
    checkOutput("fwd_miss_dat", ldDat, 0);
    ldAdr[31:0] = 32'h500; ldSel = {16'h0000, 16'h0001};
    enqV = 1; enqAdr = 32'h500; enqSel = 16'hFFFF; enqDat = {16{8'hCC}}; enqThread = 0;
    #1;
    checkOutput("fwd_same_cycle", ldHit, 0);
    @(posedge clk);
    #1;
    enqV = 0;
    #1;
    checkOutput("fwd_next_cycle_hit", ldHit, 2'b01);
    checkOutput("fwd_next_cycle_dat", ldDat[7:0], 8'hCC);
    ldSel = '0;

    $display("[TB] rollback");
    doReset();
    applyStimulus(1, 32'h600, 16'hFFFF, 8'h01, 0, 0, 0);
    applyStimulus(1, 32'h610, 16'hFFFF, 8'h02, 2, 0, 0);
    applyStimulus(1, 32'h620, 16'hFFFF, 8'h03, 0, 0, 0);
    applyStimulus(1, 32'h630, 16'hFFFF, 8'h04, 2, 0, 0);
    checkOutput("rb_busy_before", threadBusy, 4'b0101);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001);
    checkOutput("rb_busy_after", threadBusy, 4'b0100);
    checkOutput("rb_count", count, 4);
    checkOutput("rb_dead_head", deqV, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("rb_drain1_count", count, 3);
    checkOutput("rb_drain1_v", deqV, 1);
    checkOutput("rb_drain1_adr", deqAdr, 32'h610);
    checkOutput("rb_drain1_thread", deqThread, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("rb_drain2_count", count, 2);
    checkOutput("rb_drain2_v", deqV, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rb_auto_count", count, 1);
    checkOutput("rb_auto_adr", deqAdr, 32'h630);
    checkOutput("rb_auto_v", deqV, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("rb_drained", empty, 1);
    applyStimulus(1, 32'h700, 16'hFFFF, 8'h55, 3, 0, 4'b1000);
    checkOutput("rb_enq_dead_count", count, 1);
    checkOutput("rb_enq_dead_v", deqV, 0);
    checkOutput("rb_enq_dead_busy", threadBusy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rb_enq_dead_retired", count, 0);

    $display("[TB] simultaneous");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h800 + i*16, 16'hFFFF, 8'(i), 0, 0, 0);
    checkOutput("sim_count3", count, 3);
    applyStimulus(1, 32'h830, 16'hFFFF, 8'h33, 0, 1, 0);
    checkOutput("sim_both_count", count, 3);
    checkOutput("sim_head_adv", deqAdr, 32'h810);
    ldAdr[31:0] = 32'h830; ldSel = {16'h0000, 16'h0001};
    #1;
    checkOutput("sim_tail_adv", ldHit, 2'b01);
    ldSel = '0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h840 + i*16, 16'hFFFF, 8'h44, 0, 0, 0);
    checkOutput("sim_full", full, 1);
    checkOutput("sim_full_rdy", enqRdy, 0);
    applyStimulus(1, 32'h890, 16'hFFFF, 8'h89, 0, 1, 0);
    checkOutput("sim_full_both_count", count, 7);
    checkOutput("sim_full_head", deqAdr, 32'h820);
    ldAdr[31:0] = 32'h890; ldSel = {16'h0000, 16'h0001};
    #1;
    checkOutput("sim_full_rejected", ldHit, 0);
    ldSel = '0;

    $display("[TB] merge vs retiring head");
    doReset();
    applyStimulus(1, 32'h900, 16'h0001, 8'h01, 1, 0, 0);
    applyStimulus(1, 32'h900, 16'h0002, 8'h02, 1, 1, 0);
    checkOutput("retire_merge_count", count, 1);
    checkOutput("retire_merge_sel", deqSel, 16'h0002);
    checkOutput("retire_merge_dat", deqDat[15:8], 8'h02);

    $display("[TB] async reset");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'hA00 + i*16, 16'hFFFF, 8'h5A, 0, 0, 0);
    checkOutput("ares_count5", count, 5);
    ldAdr[31:0] = 32'hA00; ldSel = {16'h0000, 16'h0001};
    #1;
    checkOutput("ares_pre_hit", ldHit, 2'b01);
    rst = 1'b1;
    #1;
    checkOutput("ares_empty", empty, 1);
    checkOutput("ares_deq_v", deqV, 0);
    checkOutput("ares_ld_hit", ldHit, 0);
    checkOutput("ares_count", count, 0);
    rst = 1'b0;
    ldSel = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
